bram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, one-cycle-latency block RAM (the core's unified instruction/data memory) between an instruction-fetch port (port 0) and a load/store port (port 1). It resolves contention with round-robin priority and supports an exclusive lock for read-modify-write sequences. It drives the BRAM's ce/we/addr/din and routes read responses back to the winning requester with a valid strobe. It sits between the core's fetch/LSU units and the BRAM instance.

---
 rtl/bram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one single-port, one-cycle-latency block RAM between the
// instruction-fetch port (port 0) and the load/store port (port 1).
// Contention is resolved round-robin. A port can take an exclusive lock
// so that a read-modify-write sequence is not interleaved with the other port.
// Read data from the BRAM goes to both ports and is qualified by each
// port's rvalid strobe.

module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  // port 0: instruction fetch
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p0_lock,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,

  // port 1: load/store
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_lock,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,

  // BRAM side
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  // Index of the port granted most recently; the other port wins a tie.
  logic       rr_last;
  // Exclusive ownership: while lock_active only lock_owner can be granted.
  logic       lock_active;
  logic       lock_owner;
  // One bit per port: a read was granted on the previous edge.
  logic [1:0] rd_pend;

  // Lock request currently presented by whichever port owns the lock.
  logic       owner_lock;

  assign owner_lock = lock_owner ? p1_lock : p0_lock;

  // Grant selection: reset blocks everything, a lock restricts the grant to
  // its owner, otherwise a lone requester wins and a tie goes round-robin.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the if/else tree can leave it unassigned and infer a latch.
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (lock_active) begin
        // The non-owner is held off even when the owner is idle.
        if (lock_owner) p1_gnt = p1_req;
        else            p0_gnt = p0_req;
      end else if (p0_req && p1_req) begin
        if (rr_last) p0_gnt = 1'b1;
        else         p1_gnt = 1'b1;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  // BRAM command mux: the granted port drives the RAM; with no grant the
  // address and data simply follow port 0 and the RAM is disabled.
  always_comb begin
    mem_ce   = p0_gnt | p1_gnt;
    mem_we   = p1_gnt ? p1_we    : (p0_gnt & p0_we);
    mem_addr = p1_gnt ? p1_addr  : p0_addr;
    mem_din  = p1_gnt ? p1_wdata : p0_wdata;
  end

  // Round-robin history: remember which port took the last grant.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design updates together from the values seen before the edge.
    if (rst) begin
      rr_last <= 1'b1;
    end else if (p0_gnt) begin
      rr_last <= 1'b0;
    end else if (p1_gnt) begin
      rr_last <= 1'b1;
    end
  end

  // Lock tracking: taken by a grant with lock set, released on any cycle in
  // which the owner stops asserting its lock, whether or not it is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
    end else if (lock_active) begin
      if (!owner_lock) lock_active <= 1'b0;
    end else if (p0_gnt && p0_lock) begin
      lock_active <= 1'b1;
      lock_owner  <= 1'b0;
    end else if (p1_gnt && p1_lock) begin
      lock_active <= 1'b1;
      lock_owner  <= 1'b1;
    end
  end

  // Read-response tracking: a granted read returns data one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 2'b00;
    end else begin
      rd_pend[0] <= p0_gnt && p0_req && !p0_we;
      rd_pend[1] <= p1_gnt && p1_req && !p1_we;
    end
  end

  // A read granted just before reset is dropped: its strobe is masked in
  // the reset cycle and the pending bit is cleared by that edge.
  assign p0_rvalid = rd_pend[0] & ~rst;
  assign p1_rvalid = rd_pend[1] & ~rst;

  // Both ports see the BRAM output directly.
  assign p0_rdata = mem_dout;
  assign p1_rdata = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter with a read-first BRAM model.
// Stimulus pushes expected read data into per-port queues when it issues a
// read; a monitor pops and compares whenever a port raises rvalid.

module tb_bram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [DW-1:0] mem [1024];

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_lock  (p0_lock),
    .p0_gnt   (p0_gnt),
    .p0_rvalid(p0_rvalid),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_lock  (p1_lock),
    .p1_gnt   (p1_gnt),
    .p1_rvalid(p1_rvalid),
    .p1_rdata (p1_rdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first single-port BRAM with a registered output.
  // NOTE: only the output register is reset; the storage array keeps its
  // contents across reset, as a real block RAM does.
  always @(posedge clk) begin
    if (rst) begin
      mem_dout <= '0;
    end else if (mem_ce) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor for port 0 responses.
  always @(negedge clk) begin
    if (p0_rvalid === 1'b1) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        check("p0_rdata", p0_rdata, q0[0].data);
        void'(q0.pop_front());
      end else begin
        check("p0_rvalid_unexpected", p0_rvalid, 1'b0);
      end
    end else if (q0.size() > 0 && q0[0].due == cyc) begin
      check("p0_rvalid_missing", p0_rvalid, 1'b1);
      void'(q0.pop_front());
    end
  end

  // Monitor for port 1 responses.
  always @(negedge clk) begin
    if (p1_rvalid === 1'b1) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        check("p1_rdata", p1_rdata, q1[0].data);
        void'(q1.pop_front());
      end else begin
        check("p1_rvalid_unexpected", p1_rvalid, 1'b0);
      end
    end else if (q1.size() > 0 && q1[0].due == cyc) begin
      check("p1_rvalid_missing", p1_rvalid, 1'b1);
      void'(q1.pop_front());
    end
  end

  task automatic push0(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 1;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic lock);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_lock = lock;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic lock);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_lock = lock;
  endtask

  // Check the combinational grant and BRAM command of the current cycle.
  task automatic expect_bus(input string name, input logic g0, input logic g1,
                            input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] din, input logic chk_rv);
    @(negedge clk);
    check({name, ".p0_gnt"}, p0_gnt, g0);
    check({name, ".p1_gnt"}, p1_gnt, g1);
    check({name, ".mem_ce"}, mem_ce, g0 | g1);
    check({name, ".mem_we"}, mem_we, (g0 | g1) & we);
    if (g0 | g1) check({name, ".mem_addr"}, mem_addr, addr);
    if ((g0 | g1) & we) check({name, ".mem_din"}, mem_din, din);
    if (chk_rv) begin
      check({name, ".p0_rvalid"}, p0_rvalid, 1'b0);
      check({name, ".p1_rvalid"}, p1_rvalid, 1'b0);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = 32'h0000_0011;
    mem[10'h020] = 32'h0000_0022;
    mem[10'h3FF] = 32'h1234_5678;

    // Reset with both ports requesting: no grant may leak out.
    rst = 1'b1;
    set_p0(1, 0, '0, '0, 0);
    set_p1(1, 0, '0, '0, 0);
    next();
    expect_bus("rst_a", 0, 0, 0, '0, '0, 1); next();
    expect_bus("rst_b", 0, 0, 0, '0, '0, 1);
    rst = 1'b0;
    set_p0(0, 0, '0, '0, 0);
    set_p1(1, 1, 10'h005, 32'hDEAD_BEEF, 0);
    next();

    // Port 1 write, then port 0 read of the same word.
    expect_bus("t1_wr", 0, 1, 1, 10'h005, 32'hDEAD_BEEF, 0); next();
    set_p1(0, 0, '0, '0, 0);
    set_p0(1, 0, 10'h005, '0, 0);
    push0(32'hDEAD_BEEF);
    expect_bus("t1_rd", 1, 0, 0, 10'h005, '0, 0); next();
    set_p0(0, 0, '0, '0, 0);
    expect_bus("t1_idle", 0, 0, 0, '0, '0, 0); next();

    // Fresh reset, then both ports read continuously: 0,1,0,1,0.
    rst = 1'b1;
    expect_bus("t2_rst", 0, 0, 0, '0, '0, 1); next();
    rst = 1'b0;
    set_p0(1, 0, 10'h010, '0, 0);
    set_p1(1, 0, 10'h020, '0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        push0(32'h0000_0011);
        expect_bus("t2_rr0", 1, 0, 0, 10'h010, '0, 0);
      end else begin
        push1(32'h0000_0022);
        expect_bus("t2_rr1", 0, 1, 0, 10'h020, '0, 0);
      end
      next();
    end

    // Port 1 locked read-modify-write while port 0 keeps requesting.
    set_p1(1, 0, 10'h3FF, '0, 1);
    push1(32'h1234_5678);
    expect_bus("t3_lock_rd", 0, 1, 0, 10'h3FF, '0, 0); next();
    set_p1(0, 0, 10'h3FF, '0, 1);
    expect_bus("t3_owner_idle", 0, 0, 0, '0, '0, 0); next();
    set_p1(1, 1, 10'h3FF, 32'h1234_5679, 0);
    expect_bus("t3_lock_wr", 0, 1, 1, 10'h3FF, 32'h1234_5679, 0); next();
    set_p1(0, 0, '0, '0, 0);
    push0(32'h0000_0011);
    expect_bus("t3_p0_after", 1, 0, 0, 10'h010, '0, 0); next();
    set_p0(1, 0, 10'h3FF, '0, 0);
    push0(32'h1234_5679);
    expect_bus("t3_readback", 1, 0, 0, 10'h3FF, '0, 0); next();

    // Port 0 write then read of the same word; the bus in the read cycle
    // still carries the pre-write (read-first) value with no rvalid.
    set_p0(1, 1, 10'h040, 32'hAAAA_0000, 0);
    expect_bus("t4_wr", 1, 0, 1, 10'h040, 32'hAAAA_0000, 0); next();
    set_p0(1, 0, 10'h040, '0, 0);
    push0(32'hAAAA_0000);
    expect_bus("t4_rd", 1, 0, 0, 10'h040, '0, 0);
    check("t4_probe_rdata", p0_rdata, 32'h0000_0000);
    check("t4_probe_rvalid", p0_rvalid, 1'b0);
    next();

    // Reset right after a port 0 read grant: that read never returns.
    set_p0(1, 0, 10'h010, '0, 0);
    expect_bus("t5_rd", 1, 0, 0, 10'h010, '0, 0); next();
    rst = 1'b1;
    set_p1(1, 0, 10'h020, '0, 0);
    expect_bus("t5_rst", 0, 0, 0, '0, '0, 1); next();
    rst = 1'b0;
    push0(32'h0000_0011);
    expect_bus("t5_first", 1, 0, 0, 10'h010, '0, 1); next();
    push1(32'h0000_0022);
    expect_bus("t5_second", 0, 1, 0, 10'h020, '0, 0); next();
    set_p0(0, 0, '0, '0, 0);
    set_p1(0, 0, '0, '0, 0);
    expect_bus("t5_drain", 0, 0, 0, '0, '0, 0); next();

    // Idle for five cycles: nothing moves.
    for (int i = 0; i < 5; i++) begin
      expect_bus("t6_idle", 0, 0, 0, '0, '0, 1);
      next();
    end

    check("sb_q0_empty", q0.size(), 0);
    check("sb_q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
